// File: rtl/dip_settings_bank.sv
// dip_settings_bank: bridge-mapped bank of NUM_FIELDS settings registers.
// Host writes go to a staged copy. The core-facing live copy changes only on an
// explicit commit, and that commit can be held off until the next frame_sync so
// the core never sees a setting change in the middle of a frame.
module dip_settings_bank #(
  parameter logic [31:0]                   BASE_ADDR     = 32'h0020_0000,
  parameter int                            NUM_FIELDS    = 8,
  parameter int                            FIELD_W       = 4,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] DEFAULTS      = '0,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX     = '1,
  parameter bit                            COMMIT_MODE   = 1'b1,
  parameter bit                            SYNC_TO_FRAME = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   bridge_addr,
  input  logic                          bridge_wr,
  input  logic [31:0]                   bridge_wr_data,
  input  logic                          bridge_rd,
  output logic [31:0]                   bridge_rd_data,
  output logic                          bridge_rd_data_valid,
  input  logic                          frame_sync,
  output logic [NUM_FIELDS*FIELD_W-1:0] settings,
  output logic                          settings_changed,
  output logic                          pending
);

  localparam int SW = NUM_FIELDS * FIELD_W;

  typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

  state_t             state;
  logic [SW-1:0]      staged;
  logic [SW-1:0]      live;
  logic [SW-1:0]      staged_nxt;
  logic [SW-1:0]      live_nxt;
  logic               changed_nxt;
  logic               cnt_inc;
  logic [15:0]        apply_cnt;
  logic               err;
  logic               armed;

  logic [31:0]        offset;
  logic [4:0]         idx;
  logic               in_field;
  logic               in_live;
  logic               in_ctrl;
  logic               in_cnt;
  logic               over_max;
  logic               wr_field;
  logic               wr_ok;
  logic               wr_ctrl;
  logic               do_restore;
  logic               do_revert;
  logic               do_commit;
  logic [31:0]        rd_next;
  logic               unused_addr_lsbs;

  // Select field i out of a packed vector; indices past the last field yield 0.
  function automatic logic [FIELD_W-1:0] field_of(input logic [SW-1:0] v, input logic [4:0] i);
    field_of = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (i == 5'(k)) field_of = v[k*FIELD_W +: FIELD_W];
    end
  endfunction

  // Byte-lane bits of the address carry no meaning for word-mapped registers.
  assign unused_addr_lsbs = ^bridge_addr[1:0];

  // Address decode relative to the bank base, on the word-aligned address.
  always_comb begin
    offset   = {bridge_addr[31:2], 2'b00} - BASE_ADDR;
    idx      = offset[6:2];
    in_field = (offset[31:7] == 25'd0) && (int'(idx) < NUM_FIELDS);
    in_live  = (offset[31:7] == 25'd1) && (int'(idx) < NUM_FIELDS);
    in_ctrl  = (offset == 32'h0000_0100);
    in_cnt   = (offset == 32'h0000_0104);
  end

  // Write qualification: range check and CTRL bit priority restore > revert > commit.
  always_comb begin
    over_max   = bridge_wr_data > 32'(field_of(FIELD_MAX, idx));
    wr_field   = bridge_wr && in_field;
    wr_ok      = wr_field && !over_max;
    wr_ctrl    = bridge_wr && in_ctrl;
    do_restore = wr_ctrl && bridge_wr_data[2];
    do_revert  = wr_ctrl && !bridge_wr_data[2] && bridge_wr_data[1];
    do_commit  = wr_ctrl && !bridge_wr_data[2] && !bridge_wr_data[1] && bridge_wr_data[0];
  end

  // Next staged copy from host field writes, revert and restore.
  always_comb begin
    staged_nxt = staged;
    if (wr_ok) begin
      for (int k = 0; k < NUM_FIELDS; k++) begin
        if (idx == 5'(k)) staged_nxt[k*FIELD_W +: FIELD_W] = bridge_wr_data[FIELD_W-1:0];
      end
    end
    if (do_restore) begin
      staged_nxt = DEFAULTS;
    end else if (do_revert && COMMIT_MODE) begin
      staged_nxt = live;
    end
  end

  // Next live copy: either mirrors staged immediately or copies it in the APPLY cycle.
  always_comb begin
    live_nxt    = live;
    changed_nxt = 1'b0;
    cnt_inc     = 1'b0;
    if (!COMMIT_MODE) begin
      if (wr_ok || do_restore) begin
        live_nxt    = staged_nxt;
        changed_nxt = 1'b1;
      end
      cnt_inc = wr_ok;
    end else if (state == APPLY) begin
      // staged as it stands now; a field write this cycle lands in staged only
      live_nxt    = staged;
      changed_nxt = 1'b1;
      cnt_inc     = 1'b1;
    end
  end

  // Commit FSM together with the staged/live copies, counter and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      staged           <= DEFAULTS;
      live             <= DEFAULTS;
      settings_changed <= 1'b0;
      apply_cnt        <= 16'd0;
      err              <= 1'b0;
    end else begin
      staged           <= staged_nxt;
      live             <= live_nxt;
      settings_changed <= changed_nxt;
      if (cnt_inc) apply_cnt <= apply_cnt + 16'd1;

      // a range error in the same cycle as a CTRL read stays set
      if (wr_field && over_max) begin
        err <= 1'b1;
      end else if (bridge_rd && in_ctrl) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (COMMIT_MODE && do_commit) state <= ARMED;
        end
        ARMED: begin
          // only reached from IDLE, so a frame_sync alongside the arming write is never seen
          if (do_restore || do_revert) begin
            state <= IDLE;
          end else if (!SYNC_TO_FRAME || frame_sync) begin
            state <= APPLY;
          end
        end
        APPLY: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign armed    = (state != IDLE);
  assign pending  = armed || (staged != live);
  assign settings = live;

  // Read mux on the current address; registered below with one cycle of latency.
  always_comb begin
    rd_next = 32'd0;
    if (in_field) begin
      rd_next = 32'(field_of(staged, idx));
    end else if (in_live) begin
      rd_next = 32'(field_of(live, idx));
    end else if (in_ctrl) begin
      rd_next = {29'd0, err, armed, pending};
    end else if (in_cnt) begin
      rd_next = {16'd0, apply_cnt};
    end
  end

  // Registered bridge read data and its valid strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bridge_rd_data       <= 32'd0;
      bridge_rd_data_valid <= 1'b0;
    end else begin
      bridge_rd_data       <= rd_next;
      bridge_rd_data_valid <= bridge_rd;
    end
  end

endmodule

// File: tb/tb_dip_settings_bank.sv
// Testbench for dip_settings_bank: read results are checked through a scoreboard
// queue, status outputs are checked directly, all through one check task.
module tb_dip_settings_bank;

  localparam logic [31:0] BASE = 32'h0020_0000;
  localparam logic [31:0] CTRL = BASE + 32'h100;
  localparam logic [31:0] CNT  = BASE + 32'h104;
  localparam logic [31:0] DEF  = 32'h1234_5601;
  localparam logic [31:0] FMAX = 32'hFFFF_FFF2;

  logic        clk;
  logic        reset;
  logic [31:0] bridge_addr;
  logic        bridge_wr;
  logic [31:0] bridge_wr_data;
  logic        bridge_rd;
  logic [31:0] bridge_rd_data;
  logic        bridge_rd_data_valid;
  logic        frame_sync;
  logic [31:0] settings;
  logic        settings_changed;
  logic        pending;

  int          n_cmp;
  int          n_bad;
  logic [31:0] expq[$];
  string       tagq[$];

  dip_settings_bank #(
    .BASE_ADDR    (BASE),
    .NUM_FIELDS   (8),
    .FIELD_W      (4),
    .DEFAULTS     (DEF),
    .FIELD_MAX    (FMAX),
    .COMMIT_MODE  (1'b1),
    .SYNC_TO_FRAME(1'b1)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .bridge_addr         (bridge_addr),
    .bridge_wr           (bridge_wr),
    .bridge_wr_data      (bridge_wr_data),
    .bridge_rd           (bridge_rd),
    .bridge_rd_data      (bridge_rd_data),
    .bridge_rd_data_valid(bridge_rd_data_valid),
    .frame_sync          (frame_sync),
    .settings            (settings),
    .settings_changed    (settings_changed),
    .pending             (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected read result whenever the DUT presents read data.
  always @(negedge clk) begin
    if (bridge_rd_data_valid) begin
      if (expq.size() == 0) begin
        check("rd_extra", 32'(expq.size()), 32'd1);
      end else begin
        check(tagq.pop_front(), bridge_rd_data, expq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bridge_addr    = addr;
    bridge_wr_data = data;
    bridge_wr      = 1'b1;
    tick();
    bridge_wr      = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bridge_addr = addr;
    bridge_rd   = 1'b1;
    expq.push_back(exp);
    tagq.push_back(tag);
    tick();
    bridge_rd   = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  // Wait (bounded) for the apply pulse, check live value and that the pulse is one cycle.
  task automatic expect_apply(input string tag, input logic [31:0] exp_settings);
    int seen;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (settings_changed) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_pulse"}, 32'(seen), 32'd1);
    check({tag, "_settings"}, settings, exp_settings);
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(settings_changed), 32'd0);
    tick();
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (settings_changed) hits++;
    end
    check(tag, 32'(hits), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b1;
    bridge_addr    = 32'd0;
    bridge_wr      = 1'b0;
    bridge_wr_data = 32'd0;
    bridge_rd      = 1'b0;
    frame_sync     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_settings", settings, DEF);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_rd_valid", 32'(bridge_rd_data_valid), 32'd0);
    check("rst_rd_data", bridge_rd_data, 32'd0);
    reset = 1'b0;
    tick();
    rd("rst_cnt", CNT, 32'd0);

    // staged write is visible at the field address only
    wr(BASE + 32'h08, 32'd3);
    rd("f2_staged", BASE + 32'h08, 32'd3);
    rd("f2_live", BASE + 32'h88, 32'd6);
    check("f2_pending", 32'(pending), 32'd1);
    check("f2_settings_hold", settings, DEF);
    rd("ctrl_pending", CTRL, 32'd1);

    // commit waits for frame_sync
    wr(CTRL, 32'd1);
    repeat (100) tick();
    check("armed_settings_hold", settings, DEF);
    rd("ctrl_armed", CTRL, 32'd3);
    pulse_frame();
    expect_apply("apply1", 32'h1234_5301);
    rd("cnt_1", CNT, 32'd1);
    check("apply1_pending", 32'(pending), 32'd0);

    // frame_sync together with the arming write is ignored
    wr(BASE + 32'h04, 32'd7);
    bridge_addr    = CTRL;
    bridge_wr_data = 32'd1;
    bridge_wr      = 1'b1;
    frame_sync     = 1'b1;
    tick();
    bridge_wr      = 1'b0;
    frame_sync     = 1'b0;
    expect_quiet("coinc_quiet", 5);
    check("coinc_settings", settings, 32'h1234_5301);
    rd("coinc_ctrl", CTRL, 32'd3);
    pulse_frame();
    expect_apply("apply2", 32'h1234_5371);
    rd("cnt_2", CNT, 32'd2);

    // range checking and sticky err
    wr(BASE, 32'd5);
    rd("f0_reject", BASE, 32'd1);
    rd("ctrl_err", CTRL, 32'd4);
    rd("ctrl_err_clr", CTRL, 32'd0);
    wr(BASE, 32'd2);
    rd("f0_max_ok", BASE, 32'd2);
    check("f0_max_pending", 32'(pending), 32'd1);
    wr(BASE, 32'h0000_0013);
    rd("f0_wide_reject", BASE, 32'd2);
    rd("ctrl_err_pend", CTRL, 32'd5);
    rd("ctrl_pend_only", CTRL, 32'd1);
    wr(CTRL, 32'd2);
    check("revert_pending", 32'(pending), 32'd0);
    rd("f0_reverted", BASE, 32'd1);

    // read and write of one address in one cycle returns the old value
    bridge_addr    = BASE + 32'h0C;
    bridge_wr_data = 32'd9;
    bridge_wr      = 1'b1;
    bridge_rd      = 1'b1;
    expq.push_back(32'd5);
    tagq.push_back("rw_same_cycle");
    tick();
    bridge_wr      = 1'b0;
    bridge_rd      = 1'b0;
    rd("f3_new", BASE + 32'h0C, 32'd9);
    rd("f3_lsbs_ignored", BASE + 32'h0E, 32'd9);
    wr(CTRL, 32'd2);
    rd("f3_reverted", BASE + 32'h0C, 32'd5);

    // unmapped addresses
    rd("unmap_field8", BASE + 32'h20, 32'd0);
    rd("unmap_live8", BASE + 32'hA0, 32'd0);
    rd("unmap_108", BASE + 32'h108, 32'd0);
    wr(BASE + 32'h20, 32'd1);
    check("unmap_wr_pending", 32'(pending), 32'd0);
    rd("f1_live", BASE + 32'h84, 32'd7);

    // revert while armed cancels the commit
    wr(BASE + 32'h10, 32'hA);
    wr(CTRL, 32'd1);
    rd("arm_ctrl", CTRL, 32'd3);
    wr(CTRL, 32'd2);
    rd("revert_ctrl", CTRL, 32'd0);
    rd("f4_reverted", BASE + 32'h10, 32'd4);
    pulse_frame();
    expect_quiet("revert_quiet", 6);
    rd("cnt_still_2", CNT, 32'd2);

    // CTRL bit priority
    wr(BASE + 32'h10, 32'hA);
    wr(CTRL, 32'd3);
    rd("prio_revert", CTRL, 32'd0);
    wr(BASE + 32'h10, 32'hA);
    wr(CTRL, 32'd5);
    rd("prio_restore", CTRL, 32'd1);
    rd("restore_f1", BASE + 32'h04, 32'd0);
    rd("restore_f4", BASE + 32'h10, 32'd4);
    wr(CTRL, 32'd2);
    check("prio_clean", 32'(pending), 32'd0);

    // reset while armed
    wr(BASE + 32'h14, 32'd0);
    wr(CTRL, 32'd1);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_settings", settings, DEF);
    check("arst_pending", 32'(pending), 32'd0);
    check("arst_rd_valid", 32'(bridge_rd_data_valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    pulse_frame();
    expect_quiet("arst_quiet", 6);
    check("arst_settings_after", settings, DEF);
    rd("arst_cnt", CNT, 32'd0);
    rd("arst_ctrl", CTRL, 32'd0);

    repeat (3) tick();
    check("sb_drain", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
